// File: rtl/eth_pkg.sv
// Shared widths, field positions and write-FSM state type for the
// Ethernet receive packet FIFO.
package eth_pkg;

    localparam int DATA_W  = 32;
    localparam int FIFO_W  = 34;
    localparam int SOP_BIT = 32;
    localparam int EOP_BIT = 33;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DROP
    } wr_state_t;

endpackage

// File: rtl/eth_fifo_ram.sv
// Simple dual-port RAM: one write port and one read port.
// The read port has a registered output that holds its value when not reading.
module eth_fifo_ram #(
    parameter int DEPTH  = 64,
    parameter int FIFO_W = 34
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [FIFO_W-1:0]          wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [FIFO_W-1:0]          rdata
);

    logic [FIFO_W-1:0] mem [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/eth_rx_pkt_fifo.sv
// Packet-aware store-and-forward FIFO: only complete packets become visible
// to the reader; packets that overflow or are malformed are dropped whole.
module eth_rx_pkt_fifo
    import eth_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int PKT_CNT_W  = 7,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [FIFO_W-1:0]     wr_data,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic [PKT_CNT_W-1:0]  pkt_cnt,
    output logic                  drop_pulse,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

    wr_state_t     state, state_nxt;
    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
    logic [PW-1:0] wr_ptr_nxt, commit_ptr_nxt;
    logic [PW-1:0] used;
    logic          full, sop, eop;
    logic          ram_we, commit, drop;
    logic          rd_fire, eop_read;

    assign sop      = wr_data[SOP_BIT];
    assign eop      = wr_data[EOP_BIT];
    assign used     = wr_ptr - rd_ptr;
    assign full     = (used == FULL_LVL);
    assign empty    = (commit_ptr == rd_ptr);
    assign rd_fire  = rd_en & ~empty;
    assign eop_read = rd_valid & rd_data[EOP_BIT];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        ram_we         = 1'b0;
        commit         = 1'b0;
        drop           = 1'b0;
        if (wr_en) begin
            unique case (state)
                IDLE: begin
                    if (sop) begin
                        if (full) begin
                            drop      = 1'b1;
                            state_nxt = eop ? IDLE : DROP;
                        end else begin
                            ram_we     = 1'b1;
                            wr_ptr_nxt = wr_ptr + 1'b1;
                            if (eop) begin
                                commit         = 1'b1;
                                commit_ptr_nxt = wr_ptr + 1'b1;
                            end else begin
                                state_nxt = WRITE;
                            end
                        end
                    end
                end
                WRITE: begin
                    // A stray sop or running out of space abandons the packet.
                    if (sop || full) begin
                        wr_ptr_nxt = commit_ptr;
                        drop       = 1'b1;
                        state_nxt  = eop ? IDLE : DROP;
                    end else begin
                        ram_we     = 1'b1;
                        wr_ptr_nxt = wr_ptr + 1'b1;
                        if (eop) begin
                            commit         = 1'b1;
                            commit_ptr_nxt = wr_ptr + 1'b1;
                            state_nxt      = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (eop) begin
                        state_nxt = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            rd_valid   <= 1'b0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
            pkt_cnt    <= '0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
            rd_valid   <= rd_fire;
            drop_pulse <= drop;
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            // pkt_cnt drops when the eop word is delivered on rd_data.
            case ({commit, eop_read})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    eth_fifo_ram #(
        .DEPTH  (DEPTH),
        .FIFO_W (FIFO_W)
    ) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (ram_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .re    (rd_fire),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_eth_rx_pkt_fifo.sv
// Self-checking bench for eth_rx_pkt_fifo with DEPTH=8; read data is checked
// against a scoreboard of words from packets expected to be committed.
module tb_eth_rx_pkt_fifo;

    logic        clk = 1'b0;
    logic        rstn;
    logic [33:0] wr_data;
    logic        wr_en;
    logic        rd_en;
    logic [33:0] rd_data;
    logic        rd_valid;
    logic        empty;
    logic [3:0]  pkt_cnt;
    logic        drop_pulse;
    logic [15:0] drop_cnt;

    logic [33:0] sb[$];
    int checks = 0;
    int errors = 0;
    int popped = 0;
    int pulses = 0;

    eth_rx_pkt_fifo #(
        .DEPTH      (8),
        .PKT_CNT_W  (4),
        .DROP_CNT_W (16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .pkt_cnt    (pkt_cnt),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every delivered word must match the oldest expected word.
    always @(negedge clk) begin
        if (drop_pulse) pulses++;
        if (rd_valid) begin
            logic [33:0] exp;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got %h want no word", rd_data);
            end else begin
                exp = sb.pop_front();
                popped++;
                if (rd_data !== exp) begin
                    errors++;
                    $display("FAIL rd_data got %h want %h", rd_data, exp);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send_pkt(input int n, input logic [31:0] base, input bit keep);
        for (int i = 0; i < n; i++) begin
            logic [33:0] w;
            w = {(i == n - 1), (i == 0), base + 32'(i)};
            wr_en   = 1'b1;
            wr_data = w;
            if (keep) sb.push_back(w);
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        rstn  = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rstn    = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        step();
        step();
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (rd_valid !== 1'b0)  begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        checks++; if (pkt_cnt !== 4'd0)   begin errors++; $display("FAIL reset_pkt_cnt got %0d want 0", pkt_cnt); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL reset_drop_pulse got %b want 0", drop_pulse); end
        checks++; if (rd_data !== 34'd0)  begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int p0;
        p0 = popped;
        for (int i = 0; i < 3; i++) begin
            logic [33:0] w;
            w = {(i == 2), (i == 0), 32'hA000_0000 + 32'(i)};
            wr_en   = 1'b1;
            wr_data = w;
            sb.push_back(w);
            step();
            checks++;
            if (empty !== ((i == 2) ? 1'b0 : 1'b1)) begin
                errors++; $display("FAIL basic_empty word %0d got %b want %b", i, empty, (i != 2));
            end
        end
        wr_en = 1'b0;
        checks++; if (pkt_cnt !== 4'd1) begin errors++; $display("FAIL basic_pkt_cnt got %0d want 1", pkt_cnt); end
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1;
            step();
            checks++;
            if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_rd_valid read %0d got %b want 1", i, rd_valid); end
        end
        rd_en = 1'b0;
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_rd_valid_off got %b want 0", rd_valid); end
        checks++; if (pkt_cnt !== 4'd0) begin errors++; $display("FAIL basic_pkt_cnt_after got %0d want 0", pkt_cnt); end
        checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL basic_empty_after got %b want 1", empty); end
        checks++; if (popped - p0 !== 3) begin errors++; $display("FAIL basic_words got %0d want 3", popped - p0); end
    endtask

    task automatic test_single();
        send_pkt(1, 32'h5151_0000, 1'b1);
        checks++; if (pkt_cnt !== 4'd1) begin errors++; $display("FAIL single_pkt_cnt got %0d want 1", pkt_cnt); end
        checks++; if (empty !== 1'b0)   begin errors++; $display("FAIL single_empty got %b want 0", empty); end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        step();
        step();
        checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL single_empty_after got %b want 1", empty); end
        checks++; if (pkt_cnt !== 4'd0) begin errors++; $display("FAIL single_pkt_cnt_after got %0d want 0", pkt_cnt); end
        checks++; if (rd_data !== {2'b11, 32'h5151_0000}) begin
            errors++; $display("FAIL single_rd_data_hold got %h want %h", rd_data, {2'b11, 32'h5151_0000});
        end
    endtask

    task automatic test_overflow();
        int p0, q0;
        p0 = popped;
        q0 = pulses;
        send_pkt(5, 32'hB000_0000, 1'b1);
        send_pkt(5, 32'hC000_0000, 1'b0);
        step();
        step();
        checks++; if (pulses - q0 !== 1) begin errors++; $display("FAIL ovf_pulses got %0d want 1", pulses - q0); end
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop_cnt got %0d want 1", drop_cnt); end
        checks++; if (pkt_cnt !== 4'd1)   begin errors++; $display("FAIL ovf_pkt_cnt got %0d want 1", pkt_cnt); end
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) step();
        rd_en = 1'b0;
        step();
        step();
        checks++; if (popped - p0 !== 5) begin errors++; $display("FAIL ovf_words got %0d want 5", popped - p0); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL ovf_empty got %b want 1", empty); end
        checks++; if (pkt_cnt !== 4'd0)  begin errors++; $display("FAIL ovf_pkt_cnt_after got %0d want 0", pkt_cnt); end
    endtask

    task automatic test_sop_mid();
        logic [33:0] seq [5];
        int p0;
        do_reset();
        seq[0] = {2'b01, 32'hD000_0000};
        seq[1] = {2'b00, 32'hD000_0001};
        seq[2] = {2'b01, 32'hD000_0002};
        seq[3] = {2'b00, 32'hD000_0003};
        seq[4] = {2'b10, 32'hD000_0004};
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = seq[i];
            step();
            checks++;
            if (empty !== 1'b1) begin errors++; $display("FAIL sopmid_empty word %0d got %b want 1", i, empty); end
        end
        wr_en = 1'b0;
        step();
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL sopmid_drop_cnt got %0d want 1", drop_cnt); end
        checks++; if (pkt_cnt !== 4'd0)   begin errors++; $display("FAIL sopmid_pkt_cnt got %0d want 0", pkt_cnt); end
        p0 = popped;
        send_pkt(3, 32'hE000_0000, 1'b1);
        checks++; if (pkt_cnt !== 4'd1) begin errors++; $display("FAIL sopmid_clean_pkt_cnt got %0d want 1", pkt_cnt); end
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) step();
        rd_en = 1'b0;
        step();
        step();
        checks++; if (popped - p0 !== 3) begin errors++; $display("FAIL sopmid_clean_words got %0d want 3", popped - p0); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL sopmid_clean_empty got %b want 1", empty); end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = popped;
        rd_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            send_pkt(2, 32'hF000_0000 + 32'(k * 2), 1'b1);
        end
        for (int i = 0; i < 4; i++) step();
        rd_en = 1'b0;
        step();
        step();
        checks++; if (popped - p0 !== 40) begin errors++; $display("FAIL b2b_words got %0d want 40", popped - p0); end
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL b2b_drop_cnt got %0d want 1", drop_cnt); end
        checks++; if (pkt_cnt !== 4'd0)   begin errors++; $display("FAIL b2b_pkt_cnt got %0d want 0", pkt_cnt); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL b2b_empty got %b want 1", empty); end
    endtask

    task automatic test_reset_mid();
        int p0, q0;
        send_pkt(2, 32'h1234_0000, 1'b0);
        wr_en   = 1'b1;
        wr_data = {2'b01, 32'h7700_0000};
        step();
        wr_data = {2'b00, 32'h7700_0001};
        step();
        checks++; if (pkt_cnt !== 4'd1) begin errors++; $display("FAIL rstmid_pre_pkt_cnt got %0d want 1", pkt_cnt); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL rstmid_empty got %b want 1", empty); end
        checks++; if (pkt_cnt !== 4'd0)   begin errors++; $display("FAIL rstmid_pkt_cnt got %0d want 0", pkt_cnt); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_drop_cnt got %0d want 0", drop_cnt); end
        checks++; if (rd_data !== 34'd0)  begin errors++; $display("FAIL rstmid_rd_data got %h want 0", rd_data); end
        checks++; if (rd_valid !== 1'b0)  begin errors++; $display("FAIL rstmid_rd_valid got %b want 0", rd_valid); end
        step();
        rstn = 1'b1;
        q0 = pulses;
        wr_data = {2'b00, 32'h7700_0002};
        step();
        wr_data = {2'b00, 32'h7700_0003};
        step();
        wr_data = {2'b10, 32'h7700_0004};
        step();
        wr_en = 1'b0;
        step();
        step();
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_tail_drop_cnt got %0d want 0", drop_cnt); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL rstmid_tail_empty got %b want 1", empty); end
        checks++; if (pkt_cnt !== 4'd0)   begin errors++; $display("FAIL rstmid_tail_pkt_cnt got %0d want 0", pkt_cnt); end
        checks++; if (pulses - q0 !== 0)  begin errors++; $display("FAIL rstmid_tail_pulses got %0d want 0", pulses - q0); end
        p0 = popped;
        send_pkt(1, 32'h9999_0001, 1'b1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        step();
        step();
        checks++; if (popped - p0 !== 1) begin errors++; $display("FAIL rstmid_after_words got %0d want 1", popped - p0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_overflow();
        test_sop_mid();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_leftover got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
